sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 16: entry count, power of two, >=2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have parameter FWFT, default 1: 1 = first-word-fall-through, 0 = registered standard read.
REQ-006 SHALL use AW = log2(DEPTH) for addresses.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 flush  input  1  synchronous clear of contents and pointers.
REQ-010 wr_en  input  1  write request.
REQ-011 din  input  WIDTH  write data.
REQ-012 rd_en  input  1  read request (FWFT: pop head; standard: fetch head).
REQ-013 dout  output  WIDTH  read data.
REQ-014 dout_valid  output  1  dout holds valid data.
REQ-015 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-017 overflow, underflow  output  1 each  sticky error flags.
REQ-018 clr_err  input  1  synchronous clear of overflow/underflow.

Function
REQ-019 Pointers SHALL be AW+1 bits; empty = pointers equal; full = MSBs differ, low AW bits equal; all DEPTH entries usable.
REQ-020 Write accepted iff wr_en && !full; accepted write stores din at wr_ptr, increments wr_ptr with natural wrap.
REQ-021 Read accepted iff rd_en && !empty; accepted read increments rd_ptr with natural wrap.
REQ-022 Acceptance SHALL use flags from the start of the cycle: when full, write is rejected even if a read is accepted in the same cycle; when empty, read is rejected even if a write is accepted.
REQ-023 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-024 count, full, empty, almost_* SHALL be registered and update in the cycle after the accepting edge.
REQ-025 FWFT=1: dout = mem[rd_ptr] whenever !empty; dout_valid = !empty; data written into an empty FIFO SHALL appear 1 cycle after the write edge.
REQ-026 FWFT=0: accepted read loads mem[rd_ptr] into a dout register; dout_valid high exactly one cycle after the accepting edge; dout holds its value until the next accepted read.
REQ-027 Rejected write (wr_en && full) SHALL set overflow; rejected read (rd_en && empty) SHALL set underflow; both stay set until clr_err or rst.
REQ-028 clr_err and a new error in the same cycle: the flag SHALL stay set.
REQ-029 flush SHALL zero pointers and count, set empty and almost_empty, clear dout_valid, and override wr_en/rd_en that cycle; flush SHALL NOT clear error flags.
REQ-030 Memory contents SHALL NOT be reset or cleared.

Reset
REQ-031 rst SHALL take effect asynchronously: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, dout_valid=0, dout=0, overflow=0, underflow=0.
REQ-032 Assertion mid-operation SHALL discard all stored data; the first edge after release SHALL behave as normal operation.

Structure
REQ-033 Shared package fifo_pkg SHALL hold the log2 helper function and default threshold constants; no typedefs.
REQ-034 Storage SHALL be a sub-module fifo_mem (one write port, one asynchronous read port, WIDTH x DEPTH); control logic stays in sync_fifo.

Verification
REQ-035 DEPTH=16, FWFT=1: 16 writes 0x00..0x0F -> full=1, count=16, almost_full from count 14; 17th write -> overflow=1, data unchanged.
REQ-036 Drain 16 reads -> dout 0x00..0x0F in order, empty=1 after last; extra read -> underflow=1; clr_err -> both flags 0.
REQ-037 Concurrent wr/rd for 40 cycles from count=8 -> count stays 8, pointers wrap, output order preserved.
REQ-038 Full FIFO, wr_en and rd_en same cycle -> read accepted, write rejected, overflow=1, count=15.
REQ-039 FWFT=0: write 0xA5, rd_en one cycle -> dout=0xA5, dout_valid=1 exactly one cycle after the read edge.
REQ-040 count=5, assert flush with wr_en -> next cycle count=0, empty=1; rst pulse mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and the address-width helper for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_AF_MARGIN = 2;
  localparam int unsigned DEF_AE_LEVEL  = 2;

  // Ceiling log2; DEPTH is a power of two so this is the exact address width.
  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake, data and status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_if import fifo_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
);
  localparam int unsigned AW = log2c(DEPTH);

  logic             flush;
  logic             clr_err;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, clr_err, wr_en, din, rd_en,
    input  dout, dout_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_en, din, rd_en,
    output dout, dout_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port, never cleared.
module fifo_mem import fifo_pkg::*; #(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW    = log2c(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO control: extended pointers, registered status flags, sticky errors,
// and either first-word-fall-through or registered-read output.
module sync_fifo import fifo_pkg::*; #(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - DEF_AF_MARGIN,
  parameter int unsigned AE_LEVEL = DEF_AE_LEVEL,
  parameter bit          FWFT     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);

  localparam int unsigned AW   = log2c(DEPTH);
  localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             af_q, af_d, ae_q, ae_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_acc_c, rd_acc_c;
  logic [WIDTH-1:0] rdata;

  // Acceptance uses start-of-cycle flags; flush overrides both requests.
  always_comb begin
    wr_acc_c = bus.wr_en & ~full_q  & ~bus.flush;
    rd_acc_c = bus.rd_en & ~empty_q & ~bus.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_acc_c) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    af_d    = (count_d >= AF_L);
    ae_d    = (count_d <= AE_L);
    // A fresh error wins over a simultaneous clear.
    ovf_d   = (ovf_q & ~bus.clr_err) | (bus.wr_en & full_q  & ~bus.flush);
    udf_d   = (udf_q & ~bus.clr_err) | (bus.rd_en & empty_q & ~bus.flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_acc_c),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (bus.din),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  generate
    if (FWFT) begin : g_fwft
      // Head entry is presented directly; zero while nothing is stored.
      assign bus.dout       = empty_q ? '0 : rdata;
      assign bus.dout_valid = ~empty_q;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q, dout_d;
      logic             dout_valid_q, dout_valid_d;

      always_comb begin
        dout_d       = dout_q;
        dout_valid_d = rd_acc_c;
        if (rd_acc_c) dout_d = rdata;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
        end else begin
          dout_q       <= dout_d;
          dout_valid_q <= dout_valid_d;
        end
      end

      assign bus.dout       = dout_q;
      assign bus.dout_valid = dout_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: fill/drain vector table on a FWFT instance, hand sequences
// for wrap, flush, full-with-read, async reset, and a registered-read instance.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_if #(.WIDTH(8), .DEPTH(16)) b1 ();
  sync_fifo_if #(.WIDTH(8), .DEPTH(16)) b0 ();

  sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
    .clk (clk), .rst (rst), .bus (b0.slave)
  );

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       ce;
    logic [4:0] count;
    logic       full, empty, af, ae, ovf, udf, dv;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic wr, input logic [7:0] din, input logic rd, input logic ce,
                              input logic [4:0] count, input logic full, input logic empty,
                              input logic af, input logic ae, input logic ovf, input logic udf,
                              input logic dv, input logic [7:0] dout);
    vec_t v;
    v.wr = wr; v.din = din; v.rd = rd; v.ce = ce; v.count = count;
    v.full = full; v.empty = empty; v.af = af; v.ae = ae;
    v.ovf = ovf; v.udf = udf; v.dv = dv; v.dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all1(input string tag, input vec_t v);
    chk({tag, ".count"}, 32'(b1.count), 32'(v.count));
    chk({tag, ".full"},  32'(b1.full), 32'(v.full));
    chk({tag, ".empty"}, 32'(b1.empty), 32'(v.empty));
    chk({tag, ".af"},    32'(b1.almost_full), 32'(v.af));
    chk({tag, ".ae"},    32'(b1.almost_empty), 32'(v.ae));
    chk({tag, ".ovf"},   32'(b1.overflow), 32'(v.ovf));
    chk({tag, ".udf"},   32'(b1.underflow), 32'(v.udf));
    chk({tag, ".dv"},    32'(b1.dout_valid), 32'(v.dv));
    chk({tag, ".dout"},  32'(b1.dout), 32'(v.dout));
  endtask

  task automatic step1(input logic wr, input logic [7:0] d, input logic rd, input logic fl, input logic ce);
    @(negedge clk);
    b1.wr_en = wr; b1.din = d; b1.rd_en = rd; b1.flush = fl; b1.clr_err = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic step0(input logic wr, input logic [7:0] d, input logic rd);
    @(negedge clk);
    b0.wr_en = wr; b0.din = d; b0.rd_en = rd; b0.flush = 1'b0; b0.clr_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".count1"}, 32'(b1.count), 32'd0);
    chk({tag, ".empty1"}, 32'(b1.empty), 32'd1);
    chk({tag, ".ae1"},    32'(b1.almost_empty), 32'd1);
    chk({tag, ".full1"},  32'(b1.full), 32'd0);
    chk({tag, ".af1"},    32'(b1.almost_full), 32'd0);
    chk({tag, ".dv1"},    32'(b1.dout_valid), 32'd0);
    chk({tag, ".dout1"},  32'(b1.dout), 32'd0);
    chk({tag, ".ovf1"},   32'(b1.overflow), 32'd0);
    chk({tag, ".udf1"},   32'(b1.underflow), 32'd0);
    chk({tag, ".count0"}, 32'(b0.count), 32'd0);
    chk({tag, ".dv0"},    32'(b0.dout_valid), 32'd0);
    chk({tag, ".dout0"},  32'(b0.dout), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] head;

    rst = 1'b1;
    b1.wr_en = 0; b1.din = 0; b1.rd_en = 0; b1.flush = 0; b1.clr_err = 0;
    b0.wr_en = 0; b0.din = 0; b0.rd_en = 0; b0.flush = 0; b0.clr_err = 0;
    #1;
    chk_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // Fill 0x00..0x0F, overflow, drain, underflow, clear errors.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1, 8'(i), 0, 0, 5'(i + 1), (i == 15), 0, (i + 1 >= 14), (i + 1 <= 2),
                        0, 0, 1, 8'h00));
    vecs.push_back(mk(1, 8'hFF, 0, 0, 5'd16, 1, 0, 1, 0, 1, 0, 1, 8'h00));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0, 8'h00, 1, 0, 5'(15 - i), 0, (i == 15), (15 - i >= 14), (15 - i <= 2),
                        1, 0, (i != 15), (i == 15) ? 8'h00 : 8'(i + 1)));
    vecs.push_back(mk(0, 8'h00, 1, 0, 5'd0, 0, 1, 0, 1, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 1, 5'd0, 0, 1, 0, 1, 0, 0, 0, 8'h00));

    foreach (vecs[i]) begin
      step1(vecs[i].wr, vecs[i].din, vecs[i].rd, 1'b0, vecs[i].ce);
      chk_all1($sformatf("vec%0d", i), vecs[i]);
    end

    // Concurrent traffic at count 8; pointers wrap past 32.
    for (int i = 0; i < 8; i++) begin
      step1(1, 8'(8'h20 + i), 0, 0, 0);
      q.push_back(8'(8'h20 + i));
    end
    for (int k = 0; k < 40; k++) begin
      step1(1, 8'(8'h40 + k), 1, 0, 0);
      void'(q.pop_front());
      q.push_back(8'(8'h40 + k));
      head = q[0];
      chk($sformatf("conc%0d.count", k), 32'(b1.count), 32'd8);
      chk($sformatf("conc%0d.dout", k), 32'(b1.dout), 32'(head));
    end

    // Flush at count 5 with a write in the same cycle.
    step1(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 5; i++) step1(1, 8'(8'h50 + i), 0, 0, 0);
    chk("pre_flush.count", 32'(b1.count), 32'd5);
    step1(1, 8'h99, 0, 1, 0);
    chk("flush.count", 32'(b1.count), 32'd0);
    chk("flush.empty", 32'(b1.empty), 32'd1);
    chk("flush.ae",    32'(b1.almost_empty), 32'd1);
    chk("flush.dv",    32'(b1.dout_valid), 32'd0);
    step1(1, 8'h77, 0, 0, 0);
    chk("post_flush.count", 32'(b1.count), 32'd1);
    chk("post_flush.dout",  32'(b1.dout), 32'h77);

    // Full FIFO with simultaneous write and read.
    step1(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 16; i++) step1(1, 8'(8'h80 + i), 0, 0, 0);
    chk("fill.full", 32'(b1.full), 32'd1);
    step1(1, 8'hEE, 1, 0, 0);
    chk("fullrw.count", 32'(b1.count), 32'd15);
    chk("fullrw.full",  32'(b1.full), 32'd0);
    chk("fullrw.ovf",   32'(b1.overflow), 32'd1);
    chk("fullrw.dout",  32'(b1.dout), 32'h81);

    // Clear and new error in the same cycle keeps the flag set.
    step1(0, 8'h00, 0, 1, 0);
    step1(0, 8'h00, 1, 0, 1);
    chk("clr_vs_err.udf", 32'(b1.underflow), 32'd1);
    chk("clr_vs_err.ovf", 32'(b1.overflow), 32'd0);
    for (int i = 0; i < 16; i++) step1(1, 8'(8'h10 + i), 0, 0, 0);
    step1(1, 8'h00, 0, 0, 0);
    chk("ovf_set", 32'(b1.overflow), 32'd1);

    // Asynchronous reset mid-burst, then normal operation on the first edge after release.
    @(negedge clk);
    b1.wr_en = 1; b1.din = 8'h33; b1.rd_en = 1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    b1.wr_en = 1; b1.din = 8'h3C; b1.rd_en = 0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel.count", 32'(b1.count), 32'd1);
    chk("rel.dout",  32'(b1.dout), 32'h3C);
    chk("rel.dv",    32'(b1.dout_valid), 32'd1);
    step1(0, 8'h00, 0, 0, 0);

    // Registered-read instance.
    step0(1, 8'hA5, 0);
    chk("std.wr.count", 32'(b0.count), 32'd1);
    chk("std.wr.dv",    32'(b0.dout_valid), 32'd0);
    chk("std.wr.dout",  32'(b0.dout), 32'd0);
    step0(0, 8'h00, 1);
    chk("std.rd.dv",    32'(b0.dout_valid), 32'd1);
    chk("std.rd.dout",  32'(b0.dout), 32'hA5);
    chk("std.rd.empty", 32'(b0.empty), 32'd1);
    step0(0, 8'h00, 0);
    chk("std.hold.dv",   32'(b0.dout_valid), 32'd0);
    chk("std.hold.dout", 32'(b0.dout), 32'hA5);
    step0(0, 8'h00, 1);
    chk("std.udf",      32'(b0.underflow), 32'd1);
    chk("std.udf.dv",   32'(b0.dout_valid), 32'd0);
    chk("std.udf.dout", 32'(b0.dout), 32'hA5);
    step0(1, 8'h5A, 0);
    step0(1, 8'hC3, 0);
    chk("std.two.count", 32'(b0.count), 32'd2);
    step0(0, 8'h00, 1);
    chk("std.r1.dout", 32'(b0.dout), 32'h5A);
    chk("std.r1.dv",   32'(b0.dout_valid), 32'd1);
    step0(0, 8'h00, 1);
    chk("std.r2.dout", 32'(b0.dout), 32'hC3);
    chk("std.r2.dv",   32'(b0.dout_valid), 32'd1);
    step0(0, 8'h00, 0);
    chk("std.r3.dv",   32'(b0.dout_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
